// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared CPU definitions: word size and PC op encodings
package pc_ctrl_pkg;

  localparam int WORD_SIZE = 32;

  typedef logic [2:0] op_t;

  localparam op_t OP_NEXT   = 3'd0;
  localparam op_t OP_BRANCH = 3'd1;
  localparam op_t OP_JUMP   = 3'd2;
  localparam op_t OP_CALL   = 3'd3;
  localparam op_t OP_RET    = 3'd4;

endpackage

// File: rtl/pc_ctrl_if.sv
// rtl/pc_ctrl_if.sv - op/target request and PC/stack status bundle for pc_ctrl
interface pc_ctrl_if #(
  parameter int WORD_SIZE = pc_ctrl_pkg::WORD_SIZE
);
  import pc_ctrl_pkg::*;

  logic                 stall;
  op_t                  op;
  logic [WORD_SIZE-1:0] target;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] pc_next;
  logic                 ras_empty;
  logic                 ras_full;
  logic                 ras_ovf;
  logic                 ras_unf;

  modport master (
    output stall, op, target,
    input  pc, pc_next, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, op, target,
    output pc, pc_next, ras_empty, ras_full, ras_ovf, ras_unf
  );

endinterface

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack with sticky overflow/underflow
module pc_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    top_idx;
  logic [CW-1:0]    count;

  // ptr is the next write slot; once full it also points at the oldest entry,
  // so a push while full overwrites exactly that one.
  assign top_idx = ptr - PW'(1);
  assign dout    = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (full) begin
        ovf <= 1'b1;
      end else begin
        count <= count + CW'(1);
      end
    end else if (pop) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        ptr   <= top_idx;
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - program counter register and next-PC mux with return-address stack
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int                   WORD_SIZE = pc_ctrl_pkg::WORD_SIZE,
  parameter int                   INC       = 1,
  parameter int                   RAS_DEPTH = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic     clk,
  input  logic     rst,
  pc_ctrl_if.slave bus
);

  localparam logic [WORD_SIZE-1:0] INC_W = WORD_SIZE'(INC);

  logic [WORD_SIZE-1:0] pc_q;
  logic [WORD_SIZE-1:0] pc_seq;
  logic [WORD_SIZE-1:0] pc_n;
  logic [WORD_SIZE-1:0] ras_dout;
  logic                 ras_empty;
  logic                 ras_full;
  logic                 ras_ovf;
  logic                 ras_unf;
  logic                 ras_push;
  logic                 ras_pop;

  assign pc_seq = pc_q + INC_W;

  always_comb begin
    pc_n = pc_seq;
    case (bus.op)
      OP_BRANCH:        pc_n = pc_q + bus.target;
      OP_JUMP, OP_CALL: pc_n = bus.target;
      // An empty stack makes RET fall through like NEXT.
      OP_RET:           pc_n = ras_empty ? pc_seq : ras_dout;
      default:          pc_n = pc_seq;
    endcase
  end

  assign ras_push = !bus.stall && (bus.op == OP_CALL);
  assign ras_pop  = !bus.stall && (bus.op == OP_RET);

  pc_ras #(
    .WIDTH (WORD_SIZE),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_seq),
    .dout  (ras_dout),
    .empty (ras_empty),
    .full  (ras_full),
    .ovf   (ras_ovf),
    .unf   (ras_unf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (!bus.stall) begin
      pc_q <= pc_n;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_next   = pc_n;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.ras_ovf   = ras_ovf;
  assign bus.ras_unf   = ras_unf;

endmodule
